// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared constants and grant encoding for the register-bank
//                write-port arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package regfile_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int NUM_REGS   = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int ZERO_REG   = 31;
    localparam int CNT_WIDTH  = 16;

    // Identifies which requester won the most recent transfer
    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-requester round-robin arbiter holding the last-grant flop.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   i_req_a,
    input  logic   i_req_b,
    output logic   o_gnt_a,
    output logic   o_gnt_b,
    output grant_t o_last_grant
);

    grant_t r_last_grant;
    grant_t w_last_grant_nxt;
    logic   w_gnt_a;
    logic   w_gnt_b;

    // Contested cycles go to whoever did not win last; grants are held off in reset
    always_comb begin
        w_gnt_a          = 1'b0;
        w_gnt_b          = 1'b0;
        w_last_grant_nxt = r_last_grant;
        if (!rst) begin
            if (i_req_a && i_req_b) begin
                w_gnt_a = (r_last_grant == GRANT_B);
                w_gnt_b = (r_last_grant == GRANT_A);
            end else begin
                w_gnt_a = i_req_a;
                w_gnt_b = i_req_b;
            end
        end
        if (w_gnt_a) begin
            w_last_grant_nxt = GRANT_A;
        end else if (w_gnt_b) begin
            w_last_grant_nxt = GRANT_B;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= GRANT_B;
        end else begin
            r_last_grant <= w_last_grant_nxt;
        end
    end

    assign o_gnt_a      = w_gnt_a;
    assign o_gnt_b      = w_gnt_b;
    assign o_last_grant = r_last_grant;

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_arbiter
//  Description : Shares the register bank write port between two writers and
//                drives one-hot enables plus registered write data.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
    parameter int NUM_REGS   = regfile_pkg::NUM_REGS,
    parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
    parameter int ZERO_REG   = regfile_pkg::ZERO_REG,
    parameter int CNT_WIDTH  = regfile_pkg::CNT_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  A_VALID,
    input  logic [ADDR_WIDTH-1:0] A_ADDR,
    input  logic [DATA_WIDTH-1:0] A_DATA,
    output logic                  A_READY,
    input  logic                  B_VALID,
    input  logic [ADDR_WIDTH-1:0] B_ADDR,
    input  logic [DATA_WIDTH-1:0] B_DATA,
    output logic                  B_READY,
    output logic [NUM_REGS-1:0]   REG_EN,
    output logic [DATA_WIDTH-1:0] REG_WRITE,
    output logic                  LAST_GRANT,
    output logic [CNT_WIDTH-1:0]  CONFLICT_COUNT
);

    import regfile_pkg::*;

    localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;

    logic                  w_gnt_a;
    logic                  w_gnt_b;
    grant_t                w_last_grant;
    logic                  w_xfer;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic [NUM_REGS-1:0]   w_dec;

    logic [NUM_REGS-1:0]   r_reg_en;
    logic [DATA_WIDTH-1:0] r_reg_write;
    logic [CNT_WIDTH-1:0]  r_conflict_count;

    rr_arbiter2 u_arb (
        .clk          (CLK),
        .rst          (RESET),
        .i_req_a      (A_VALID),
        .i_req_b      (B_VALID),
        .o_gnt_a      (w_gnt_a),
        .o_gnt_b      (w_gnt_b),
        .o_last_grant (w_last_grant)
    );

    assign w_xfer = w_gnt_a || w_gnt_b;
    assign w_addr = w_gnt_a ? A_ADDR : B_ADDR;
    assign w_data = w_gnt_a ? A_DATA : B_DATA;

    // The hardwired-zero register never gets an enable bit
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_decode
            assign w_dec[gi] = (w_addr == ADDR_WIDTH'(gi)) && (gi != ZERO_REG);
        end
    endgenerate

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_reg_en    <= '0;
            r_reg_write <= '0;
        end else if (w_xfer) begin
            r_reg_en    <= w_dec;
            r_reg_write <= w_data;
        end else begin
            r_reg_en    <= '0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_conflict_count <= '0;
        end else if (A_VALID && B_VALID && (r_conflict_count != c_cnt_max)) begin
            r_conflict_count <= r_conflict_count + CNT_WIDTH'(1);
        end
    end

    assign A_READY        = w_gnt_a;
    assign B_READY        = w_gnt_b;
    assign REG_EN         = r_reg_en;
    assign REG_WRITE      = r_reg_write;
    assign LAST_GRANT     = w_last_grant;
    assign CONFLICT_COUNT = r_conflict_count;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_write_arbiter
//  Description : Self-checking bench for the register bank write arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_write_arbiter;

    logic        CLK;
    logic        RESET;
    logic        A_VALID;
    logic [4:0]  A_ADDR;
    logic [63:0] A_DATA;
    logic        A_READY;
    logic        B_VALID;
    logic [4:0]  B_ADDR;
    logic [63:0] B_DATA;
    logic        B_READY;
    logic [31:0] REG_EN;
    logic [63:0] REG_WRITE;
    logic        LAST_GRANT;
    logic [15:0] CONFLICT_COUNT;

    regfile_write_arbiter dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .A_VALID        (A_VALID),
        .A_ADDR         (A_ADDR),
        .A_DATA         (A_DATA),
        .A_READY        (A_READY),
        .B_VALID        (B_VALID),
        .B_ADDR         (B_ADDR),
        .B_DATA         (B_DATA),
        .B_READY        (B_READY),
        .REG_EN         (REG_EN),
        .REG_WRITE      (REG_WRITE),
        .LAST_GRANT     (LAST_GRANT),
        .CONFLICT_COUNT (CONFLICT_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Stand-in for the register bank that consumes REG_EN/REG_WRITE
    logic [63:0] bank [32];
    always @(posedge CLK) begin
        for (int i = 0; i < 32; i++) begin
            if (REG_EN[i]) bank[i] <= REG_WRITE;
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] aa, input logic [63:0] ad,
                         input logic bv, input logic [4:0] ba, input logic [63:0] bd);
        A_VALID = av; A_ADDR = aa; A_DATA = ad;
        B_VALID = bv; B_ADDR = ba; B_DATA = bd;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1;
        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [63:0] ad;
        logic        bv;
        logic [4:0]  ba;
        logic [63:0] bd;
        logic        ear;
        logic        ebr;
        logic [31:0] een;
        logic [63:0] ewr;
        logic        elg;
    } vec_t;

    vec_t        vt [10];
    logic [4:0]  alt_a [3];
    logic [4:0]  alt_b [3];

    // Reference model state
    logic        m_last;
    int          m_cnt;
    logic [31:0] m_en;
    logic [63:0] m_wr;
    logic        pa, pb;
    logic [4:0]  qa, qb;
    logic [63:0] da, db;
    int          g;

    initial begin
        RESET = 1'b1;
        drive(1'b1, 5'd1, 64'd1, 1'b1, 5'd2, 64'd2);

        // Reset state
        #1;
        chk("rst_en", REG_EN, 64'd0);
        chk("rst_wr", REG_WRITE, 64'd0);
        chk("rst_cnt", CONFLICT_COUNT, 64'd0);
        chk("rst_lg", LAST_GRANT, 64'd1);
        chk("rst_ready", {A_READY, B_READY}, 64'd0);
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        drive(1'b1, 5'd5, 64'hDEAD_BEEF_0000_0001, 1'b0, 5'd0, 64'd0);

        // Mid-cycle reset cancels an in-flight write and keeps pending requests
        @(posedge CLK); #1;
        chk("flight_en", REG_EN, 64'h20);
        drive(1'b1, 5'd6, 64'h77, 1'b1, 5'd9, 64'h88);
        #2 RESET = 1'b1;
        #1;
        chk("async_en", REG_EN, 64'd0);
        chk("async_cnt", CONFLICT_COUNT, 64'd0);
        chk("async_lg", LAST_GRANT, 64'd1);
        chk("async_ready", {A_READY, B_READY}, 64'd0);
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk("resume_ready", {A_READY, B_READY}, 64'b10);
        @(posedge CLK); #1;
        chk("resume_en_a", REG_EN, 64'h40);
        @(negedge CLK);
        drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 64'h88);
        #1;
        chk("resume_ready_b", {A_READY, B_READY}, 64'b01);
        @(posedge CLK); #1;
        chk("resume_en_b", REG_EN, 64'h200);
        chk("resume_cnt", CONFLICT_COUNT, 64'd1);
        @(negedge CLK);
        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            chk("idle_en", REG_EN, 64'd0);
        end

        // Table-driven vectors, one cycle each, starting from A priority
        vt[0] = '{1'b1, 5'd5,  64'hDEAD_BEEF_0000_0001, 1'b0, 5'd0,  64'd0,
                  1'b1, 1'b0, 32'h0000_0020, 64'hDEAD_BEEF_0000_0001, 1'b0};
        vt[1] = '{1'b0, 5'd0,  64'd0,    1'b0, 5'd0,  64'd0,
                  1'b0, 1'b0, 32'h0, 64'hDEAD_BEEF_0000_0001, 1'b0};
        vt[2] = '{1'b1, 5'd3,  64'h1,    1'b1, 5'd3,  64'h2,
                  1'b0, 1'b1, 32'h8, 64'h2, 1'b1};
        vt[3] = '{1'b1, 5'd3,  64'h1,    1'b1, 5'd7,  64'h5,
                  1'b1, 1'b0, 32'h8, 64'h1, 1'b0};
        vt[4] = '{1'b0, 5'd0,  64'd0,    1'b1, 5'd7,  64'h5,
                  1'b0, 1'b1, 32'h80, 64'h5, 1'b1};
        vt[5] = '{1'b0, 5'd0,  64'd0,    1'b1, 5'd31, 64'hFFFF,
                  1'b0, 1'b1, 32'h0, 64'hFFFF, 1'b1};
        vt[6] = '{1'b1, 5'd31, 64'h1234, 1'b0, 5'd0,  64'd0,
                  1'b1, 1'b0, 32'h0, 64'h1234, 1'b0};
        vt[7] = '{1'b1, 5'd0,  64'hA,    1'b1, 5'd30, 64'hB,
                  1'b0, 1'b1, 32'h4000_0000, 64'hB, 1'b1};
        vt[8] = '{1'b1, 5'd0,  64'hA,    1'b0, 5'd0,  64'd0,
                  1'b1, 1'b0, 32'h1, 64'hA, 1'b0};
        vt[9] = '{1'b0, 5'd0,  64'd0,    1'b0, 5'd0,  64'd0,
                  1'b0, 1'b0, 32'h0, 64'hA, 1'b0};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            drive(vt[i].av, vt[i].aa, vt[i].ad, vt[i].bv, vt[i].ba, vt[i].bd);
            #1;
            chk($sformatf("vec%0d_ready", i), {A_READY, B_READY}, {vt[i].ear, vt[i].ebr});
            @(posedge CLK); #1;
            chk($sformatf("vec%0d_en", i), REG_EN, vt[i].een);
            chk($sformatf("vec%0d_wr", i), REG_WRITE, vt[i].ewr);
            chk($sformatf("vec%0d_lg", i), LAST_GRANT, vt[i].elg);
        end
        chk("vec_cnt", CONFLICT_COUNT, 64'd3);

        // Conflict alternation: A, B, A, B with reissue after each grant
        alt_a[0] = 5'd1;  alt_a[1] = 5'd2;  alt_a[2] = 5'd3;
        alt_b[0] = 5'd10; alt_b[1] = 5'd11; alt_b[2] = 5'd12;
        do_reset();
        begin
            int ai = 0;
            int bi = 0;
            for (int c = 0; c < 4; c++) begin
                logic want_a;
                want_a = (c % 2 == 0);
                @(negedge CLK);
                drive(1'b1, alt_a[ai], 64'(100 + ai), 1'b1, alt_b[bi], 64'(200 + bi));
                #1;
                chk($sformatf("alt%0d_ready", c), {A_READY, B_READY}, want_a ? 64'b10 : 64'b01);
                @(posedge CLK); #1;
                chk($sformatf("alt%0d_en", c), REG_EN,
                    64'(32'd1 << (want_a ? alt_a[ai] : alt_b[bi])));
                chk($sformatf("alt%0d_wr", c), REG_WRITE,
                    want_a ? 64'(100 + ai) : 64'(200 + bi));
                if (want_a) ai++; else bi++;
            end
        end
        chk("alt_cnt", CONFLICT_COUNT, 64'd4);

        // Same address from both requesters: loser's data lands last
        do_reset();
        @(negedge CLK);
        drive(1'b1, 5'd3, 64'h1, 1'b1, 5'd3, 64'h2);
        #1;
        chk("same_ready_a", {A_READY, B_READY}, 64'b10);
        @(posedge CLK); #1;
        chk("same_en1", REG_EN, 64'h8);
        chk("same_wr1", REG_WRITE, 64'h1);
        @(negedge CLK);
        drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd3, 64'h2);
        #1;
        chk("same_ready_b", {A_READY, B_READY}, 64'b01);
        @(posedge CLK); #1;
        chk("same_en2", REG_EN, 64'h8);
        chk("same_wr2", REG_WRITE, 64'h2);
        @(negedge CLK);
        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        @(posedge CLK); #1;
        chk("same_x3", bank[3], 64'h2);

        // Randomised traffic against the behavioural model
        do_reset();
        m_last = 1'b1; m_cnt = 0; m_en = '0; m_wr = '0;
        pa = 1'b0; pb = 1'b0; qa = '0; qb = '0; da = '0; db = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            if (!pa && ($urandom_range(0, 2) != 0)) begin
                pa = 1'b1; qa = 5'($urandom_range(0, 31)); da = {$urandom, $urandom};
            end
            if (!pb && ($urandom_range(0, 2) != 0)) begin
                pb = 1'b1; qb = 5'($urandom_range(0, 31)); db = {$urandom, $urandom};
            end
            drive(pa, qa, da, pb, qb, db);
            if (pa && pb)  g = m_last ? 0 : 1;
            else if (pa)   g = 0;
            else if (pb)   g = 1;
            else           g = -1;
            #1;
            chk("rnd_ready", {A_READY, B_READY}, {62'd0, g == 0, g == 1});
            @(posedge CLK);
            if (pa && pb && m_cnt < 65535) m_cnt++;
            if (g == 0) begin
                m_last = 1'b0; m_wr = da; pa = 1'b0;
                m_en = (qa == 5'd31) ? 32'd0 : (32'd1 << qa);
            end else if (g == 1) begin
                m_last = 1'b1; m_wr = db; pb = 1'b0;
                m_en = (qb == 5'd31) ? 32'd0 : (32'd1 << qb);
            end else begin
                m_en = '0;
            end
            #1;
            chk("rnd_en", REG_EN, m_en);
            chk("rnd_wr", REG_WRITE, m_wr);
            chk("rnd_lg", LAST_GRANT, m_last);
            chk("rnd_cnt", CONFLICT_COUNT, 64'(m_cnt));
        end

        // Counter saturation, then a reset pulse mid-run
        do_reset();
        @(negedge CLK);
        drive(1'b1, 5'd1, 64'h11, 1'b1, 5'd2, 64'h22);
        repeat (100) @(posedge CLK);
        #1;
        chk("sat_cnt100", CONFLICT_COUNT, 64'd100);
        repeat (65500) @(posedge CLK);
        #1;
        chk("sat_cnt_max", CONFLICT_COUNT, 64'hFFFF);
        #2 RESET = 1'b1;
        #1;
        chk("sat_rst_cnt", CONFLICT_COUNT, 64'd0);
        chk("sat_rst_lg", LAST_GRANT, 64'd1);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk("sat_after_ready", {A_READY, B_READY}, 64'b10);
        @(posedge CLK); #1;
        chk("sat_after_cnt", CONFLICT_COUNT, 64'd1);
        chk("sat_after_lg", LAST_GRANT, 64'd0);
        @(negedge CLK);
        drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
